// File: rtl/nano_rv32i_pkg.sv
// Shared types and defaults for the nano_rv32i memory-side blocks.
// Source IDs tag each memory transaction so its response can be steered back.
package nano_rv32i_pkg;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_id_t;

  localparam int MAX_OUT_DEFAULT      = 2;
  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/nano_id_fifo.sv
// Small circular-buffer FIFO with wrap-around pointers; zero-latency head (show-ahead).
// Pushes while full and pops while empty are ignored.
module nano_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (cnt == CW'(DEPTH));
  assign empty_o    = (cnt == '0);
  assign count_o    = cnt;
  assign pop_data_o = mem[rd_ptr];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/nano_mem_arbiter.sv
// Two-to-one instruction/data memory arbiter, zero-latency grant and response path.
// Data has priority; a starve counter forces an instruction grant; stalls when MAX_OUT are in flight.
module nano_mem_arbiter
  import nano_rv32i_pkg::*;
#(
  parameter int MAX_OUT      = MAX_OUT_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic [3:0]  d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        m_req_o,
  output logic [3:0]  m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_gnt_i,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  output logic        err_o
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [0:0]    fifo_head;
  src_id_t       push_id;
  src_id_t       head_id;
  logic [3:0]    starve_cnt;
  logic          starved;
  logic          sel_i;
  logic          xfer;
  logic          pop;

  assign starved = i_req_i & (starve_cnt == 4'(STARVE_LIMIT));
  assign sel_i   = ~d_req_i | starved;

  // full comes from registered state only, so m_rvalid_i never reaches m_req_o.
  assign m_req_o = (i_req_i | d_req_i) & ~fifo_full & ~rst_i;
  assign xfer    = m_req_o & m_gnt_i;
  assign i_gnt_o = xfer & sel_i;
  assign d_gnt_o = xfer & ~sel_i;

  always_comb begin
    m_we_o    = '0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (m_req_o) begin
      if (sel_i) begin
        m_addr_o = i_addr_i;
      end else begin
        m_we_o    = d_we_i;
        m_addr_o  = d_addr_i;
        m_wdata_o = d_wdata_i;
      end
    end
  end

  assign push_id = sel_i ? SRC_I : SRC_D;
  assign head_id = src_id_t'(fifo_head);
  assign pop     = m_rvalid_i & ~fifo_empty;

  nano_id_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (xfer),
    .push_data_i (push_id),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign i_rvalid_o = pop & (head_id == SRC_I);
  assign d_rvalid_o = pop & (head_id == SRC_D);
  assign i_rdata_o  = m_rdata_i;
  assign d_rdata_o  = m_rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (~i_req_i | i_gnt_o) begin
      starve_cnt <= '0;
    end else if (d_gnt_o && (starve_cnt != 4'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // An orphan response has no owner to steer to; it is dropped and flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (m_rvalid_i && (fifo_count == '0)) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Bench for nano_mem_arbiter: directed scenarios with literal expectations plus a
// transaction-level model (outstanding queue, memory array) compared every cycle.
module tb_nano_mem_arbiter;

  localparam int MAX_OUT      = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i, d_req_i;
  logic [31:0] i_addr_i, d_addr_i, d_wdata_i;
  logic [3:0]  d_we_i;
  logic        i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o;
  logic [31:0] i_rdata_o, d_rdata_o;
  logic        m_req_o;
  logic [3:0]  m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic        m_gnt_i, m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        err_o;

  nano_mem_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        src;   // 0 = instruction, 1 = data
    logic        rd;
    logic [31:0] d;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] pend[$];
  logic [31:0] mem [logic [31:0]];
  int          consec_d = 0;
  logic        err_exp  = 1'b0;

  logic  gnt_on = 1'b1, rsp_on = 1'b1, inj = 1'b0;
  logic  i_gnt_seen = 1'b0, d_gnt_seen = 1'b0;
  string gs = "", rs = "";
  logic [31:0] last_i_rdata = '0, last_d_rdata = '0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chks(input string nm, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got '%s' want '%s'", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory side: accepts per gnt_on, answers oldest pending request when rsp_on.
  always @(posedge clk_i) begin
    #2;
    m_gnt_i = gnt_on;
    if (inj) begin
      m_rvalid_i = 1'b1;
      m_rdata_i  = 32'h0BAD_0BAD;
    end else if (rsp_on && pend.size() > 0) begin
      m_rvalid_i = 1'b1;
      m_rdata_i  = pend[0];
    end else begin
      m_rvalid_i = 1'b0;
      m_rdata_i  = '0;
    end
  end

  // Compare process: model expectations vs DUT, then advance model and memory.
  always @(negedge clk_i) begin : cmp
    logic        full, e_mreq, sel_i, e_ig, e_dg, have, e_irv, e_drv;
    logic [31:0] ea, ewd, wv;
    logic [3:0]  ewe;
    ent_t        ent;
    if (rst_i) begin
      chk1("rst_m_req", m_req_o, 1'b0);
      chk1("rst_i_gnt", i_gnt_o, 1'b0);
      chk1("rst_d_gnt", d_gnt_o, 1'b0);
      chk1("rst_i_rvalid", i_rvalid_o, 1'b0);
      chk1("rst_d_rvalid", d_rvalid_o, 1'b0);
      chk1("rst_err", err_o, 1'b0);
      chk32("rst_m_addr", m_addr_o, 32'h0);
      chk32("rst_m_wdata", m_wdata_o, 32'h0);
      chk32("rst_m_we", {28'h0, m_we_o}, 32'h0);
      exp_q.delete();
      pend.delete();
      consec_d   = 0;
      err_exp    = 1'b0;
      i_gnt_seen = 1'b0;
      d_gnt_seen = 1'b0;
    end else begin
      full   = (exp_q.size() >= MAX_OUT);
      e_mreq = (i_req_i || d_req_i) && !full;
      sel_i  = !d_req_i || (i_req_i && consec_d >= STARVE_LIMIT);
      e_ig   = e_mreq && m_gnt_i && sel_i;
      e_dg   = e_mreq && m_gnt_i && !sel_i;
      have   = (exp_q.size() > 0);
      e_irv  = m_rvalid_i && have && (exp_q[0].src == 1'b0);
      e_drv  = m_rvalid_i && have && (exp_q[0].src == 1'b1);
      ea     = sel_i ? i_addr_i : d_addr_i;
      ewe    = sel_i ? 4'h0 : d_we_i;
      ewd    = sel_i ? 32'h0 : d_wdata_i;

      chk1("m_req", m_req_o, e_mreq);
      chk1("i_gnt", i_gnt_o, e_ig);
      chk1("d_gnt", d_gnt_o, e_dg);
      chk1("i_rvalid", i_rvalid_o, e_irv);
      chk1("d_rvalid", d_rvalid_o, e_drv);
      chk1("err", err_o, err_exp);
      if (e_mreq) begin
        chk32("m_addr", m_addr_o, ea);
        chk32("m_we", {28'h0, m_we_o}, {28'h0, ewe});
        chk32("m_wdata", m_wdata_o, ewd);
      end
      if (e_irv || e_drv) begin
        chk32("i_rdata_pass", i_rdata_o, m_rdata_i);
        chk32("d_rdata_pass", d_rdata_o, m_rdata_i);
        if (exp_q[0].rd) chk32(e_irv ? "i_rdata" : "d_rdata", m_rdata_i, exp_q[0].d);
      end

      if (i_gnt_o) gs = {gs, "I"};
      if (d_gnt_o) gs = {gs, "D"};
      if (i_rvalid_o) begin rs = {rs, "I"}; last_i_rdata = i_rdata_o; end
      if (d_rvalid_o) begin rs = {rs, "D"}; last_d_rdata = d_rdata_o; end
      i_gnt_seen = i_gnt_o;
      d_gnt_seen = d_gnt_o;

      if (m_rvalid_i && have) void'(exp_q.pop_front());
      if (m_rvalid_i && !have) err_exp = 1'b1;
      if (m_rvalid_i && pend.size() > 0) void'(pend.pop_front());

      if (e_ig || e_dg) begin
        ent.src = e_dg;
        ent.rd  = (ewe == 4'h0);
        ent.d   = memrd(ea);
        exp_q.push_back(ent);
      end
      if (m_req_o && m_gnt_i) begin
        wv = memrd(m_addr_o);
        for (int b = 0; b < 4; b++)
          if (m_we_o[b]) wv[8*b +: 8] = m_wdata_o[8*b +: 8];
        if (m_we_o != 4'h0) mem[m_addr_o] = wv;
        pend.push_back(wv);
      end

      if (!i_req_i || e_ig) consec_d = 0;
      else if (e_dg && consec_d < STARVE_LIMIT) consec_d++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_i(input logic [31:0] a);
    int n = 0;
    i_req_i = 1'b1; i_addr_i = a;
    @(negedge clk_i);
    while (!i_gnt_o && n < 20) begin n++; @(negedge clk_i); end
    step(1);
    i_req_i = 1'b0;
    chk1("i_grant_within_budget", (n < 20), 1'b1);
  endtask

  task automatic do_d(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    d_req_i = 1'b1; d_we_i = we; d_addr_i = a; d_wdata_i = wd;
    @(negedge clk_i);
    while (!d_gnt_o && n < 20) begin n++; @(negedge clk_i); end
    step(1);
    d_req_i = 1'b0; d_we_i = 4'h0; d_wdata_i = '0;
    chk1("d_grant_within_budget", (n < 20), 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic bp_rsp  [9] = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
  logic bp_mreq [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};

  initial begin
    rst_i = 1'b1;
    i_req_i = 0; d_req_i = 0; i_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; d_we_i = 0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0;
    step(3);
    rst_i = 1'b0;
    step(1);

    // Single instruction read, latency 1.
    gs = ""; rs = "";
    i_req_i = 1'b1; i_addr_i = 32'h10;
    @(negedge clk_i);
    chk1("single_i_gnt_cycle0", i_gnt_o, 1'b1);
    step(1);
    i_req_i = 1'b0;
    @(negedge clk_i);
    chk1("single_i_rvalid_cycle1", i_rvalid_o, 1'b1);
    chk32("single_i_rdata", i_rdata_o, 32'hA5A5_0010);
    chk1("single_d_rvalid_quiet", d_rvalid_o, 1'b0);
    step(3);

    // Both requests held continuously: starvation rotation.
    gs = ""; rs = "";
    i_req_i = 1'b1; i_addr_i = 32'h100;
    d_req_i = 1'b1; d_addr_i = 32'h200; d_we_i = 4'h0;
    step(10);
    i_req_i = 1'b0; d_req_i = 1'b0;
    step(4);
    chks("starve_grant_seq", gs, "DDDDIDDDDI");
    chks("starve_rsp_seq", rs, "DDDDIDDDDI");

    // Back-pressure with MAX_OUT outstanding.
    gs = ""; rs = "";
    d_req_i = 1'b1; d_addr_i = 32'h300; d_we_i = 4'h0;
    for (int k = 0; k < 9; k++) begin
      rsp_on = bp_rsp[k];
      @(negedge clk_i);
      chk1($sformatf("bp_m_req_%0d", k), m_req_o, bp_mreq[k]);
      if (k == 2) chk32("bp_two_grants", gs.len(), 32'd2);
      step(1);
    end
    d_req_i = 1'b0; rsp_on = 1'b1;
    step(4);
    chks("bp_grant_seq", gs, "DDDDD");

    // Write then instruction read; then read back the written word.
    gs = ""; rs = "";
    d_req_i = 1'b1; d_we_i = 4'hF; d_addr_i = 32'h4; d_wdata_i = 32'hDEADBEEF;
    i_req_i = 1'b1; i_addr_i = 32'h20;
    @(negedge clk_i);
    chk1("wr_d_gnt_first", d_gnt_o, 1'b1);
    chk32("wr_m_we", {28'h0, m_we_o}, 32'hF);
    step(1);
    d_req_i = 1'b0; d_we_i = 4'h0; d_wdata_i = '0;
    @(negedge clk_i);
    chk1("wr_i_gnt_second", i_gnt_o, 1'b1);
    step(1);
    i_req_i = 1'b0;
    step(3);
    chks("wr_rsp_order", rs, "DI");
    rs = "";
    do_d(4'h0, 32'h4, 32'h0);
    step(3);
    chks("rd_back_rsp", rs, "D");
    chk32("rd_back_data", last_d_rdata, 32'hDEADBEEF);

    // Orphan response sets sticky error.
    inj = 1'b1;
    @(negedge clk_i);
    chk1("orphan_no_i_rvalid", i_rvalid_o, 1'b0);
    chk1("orphan_no_d_rvalid", d_rvalid_o, 1'b0);
    step(1);
    inj = 1'b0;
    @(negedge clk_i);
    chk1("orphan_err_set", err_o, 1'b1);
    step(4);
    chk1("orphan_err_sticky", err_o, 1'b1);

    // Reset mid-burst with two outstanding.
    rsp_on = 1'b0;
    do_d(4'h0, 32'h40, 32'h0);
    do_d(4'h0, 32'h44, 32'h0);
    rst_i = 1'b1; i_req_i = 1'b1; d_req_i = 1'b1;
    @(negedge clk_i);
    chk1("rst_burst_i_gnt", i_gnt_o, 1'b0);
    chk1("rst_burst_d_gnt", d_gnt_o, 1'b0);
    chk1("rst_burst_err", err_o, 1'b0);
    step(2);
    rst_i = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0; rsp_on = 1'b1;
    gs = ""; rs = "";
    @(negedge clk_i);
    chk1("post_rst_err", err_o, 1'b0);
    step(1);
    do_i(32'h10);
    step(3);
    chks("post_rst_rsp", rs, "I");
    chk32("post_rst_i_rdata", last_i_rdata, 32'hA5A5_0010);

    // Randomised traffic with memory stalls, checked by the model every cycle.
    for (int c = 0; c < 300; c++) begin
      gnt_on = ($urandom_range(0, 3) != 0);
      rsp_on = ($urandom_range(0, 2) != 0);
      if (!i_req_i || i_gnt_seen) begin
        i_req_i  = ($urandom_range(0, 1) != 0);
        i_addr_i = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!d_req_i || d_gnt_seen) begin
        d_req_i   = ($urandom_range(0, 2) != 0);
        d_addr_i  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d_we_i    = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
        d_wdata_i = $urandom;
      end
      step(1);
    end
    i_req_i = 1'b0; d_req_i = 1'b0; gnt_on = 1'b1; rsp_on = 1'b1;
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
